// File: rtl/fifo_ptr_pkg.sv
//------------------------------------------------------------------------------
// Module  : fifo_ptr_pkg
// Brief   : Shared Gray/binary conversion helpers and constants for FIFO pointers
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_ptr_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int FN_W            = 32;

    // Callers zero-extend narrower pointers; bits at or above width are ignored.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray,
                                                 input int              width);
        logic [FN_W-1:0] bin;
        logic            acc;
        bin = '0;
        acc = 1'b0;
        for (int i = FN_W - 1; i >= 0; i--) begin
            if (i < width) begin
                acc = acc ^ gray[i];
            end
            bin[i] = (i < width) ? acc : 1'b0;
        end
        return bin;
    endfunction

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin,
                                                 input int              width);
        logic [FN_W-1:0] mask;
        mask = (width >= FN_W) ? '1 : ((FN_W'(1) << width) - FN_W'(1));
        return (bin ^ (bin >> 1)) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sync.sv
//------------------------------------------------------------------------------
// Module  : gray_sync
// Brief   : Multi-bit flop synchroniser chain for Gray-coded pointers
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_sync
    import fifo_ptr_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Fewer than two stages offers no metastability protection.
    localparam int c_N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [c_N-1:0][WIDTH-1:0] sync_d;
    logic [c_N-1:0][WIDTH-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[c_N-2:0], i_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[c_N-1];

endmodule

`default_nettype wire

// File: rtl/rptr_handler_lvl.sv
//------------------------------------------------------------------------------
// Module  : rptr_handler_lvl
// Brief   : Async FIFO read-pointer handler with level, almost-empty, underflow.
//           Define RPTR_INT_SYNC_EN to synchronise g_wptr_in internally.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rptr_handler_lvl
    import fifo_ptr_pkg::*;
#(
    parameter int PTR_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_wptr_in,
    input  logic [PTR_WIDTH:0]   ae_thresh,
    input  logic                 clr_err,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic [PTR_WIDTH-1:0] r_addr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 underflow,
    output logic                 underflow_err
);

    localparam int c_PW = PTR_WIDTH + 1;

    logic [c_PW-1:0] w_g_wptr_sync;
    logic [c_PW-1:0] w_wbin;
    logic            w_rd_ok;

    logic [c_PW-1:0] b_rptr_d,        b_rptr_q;
    logic [c_PW-1:0] g_rptr_d,        g_rptr_q;
    logic [c_PW-1:0] rd_level_d,      rd_level_q;
    logic            empty_d,         empty_q;
    logic            almost_empty_d,  almost_empty_q;
    logic            underflow_d,     underflow_q;
    logic            underflow_err_d, underflow_err_q;

`ifdef RPTR_INT_SYNC_EN
    gray_sync #(
        .WIDTH  (c_PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .i_d   (g_wptr_in),
        .o_q   (w_g_wptr_sync)
    );
`else
    assign w_g_wptr_sync = g_wptr_in;
`endif

    assign w_wbin  = c_PW'(gray2bin(FN_W'(w_g_wptr_sync), c_PW));
    assign w_rd_ok = r_en & ~empty_q;

    // Flags are computed from the post-pop pointer so they settle with the pop.
    always_comb begin
        b_rptr_d        = b_rptr_q + c_PW'(w_rd_ok);
        g_rptr_d        = c_PW'(bin2gray(FN_W'(b_rptr_d), c_PW));
        empty_d         = (w_g_wptr_sync == g_rptr_d);
        rd_level_d      = w_wbin - b_rptr_d;
        almost_empty_d  = (rd_level_d <= ae_thresh);
        underflow_d     = r_en & empty_q;
        underflow_err_d = underflow_err_q;
        if (clr_err) begin
            underflow_err_d = 1'b0;
        end
        if (underflow_d) begin
            underflow_err_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr_q        <= '0;
            g_rptr_q        <= '0;
            rd_level_q      <= '0;
            empty_q         <= 1'b1;
            almost_empty_q  <= 1'b1;
            underflow_q     <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            b_rptr_q        <= b_rptr_d;
            g_rptr_q        <= g_rptr_d;
            rd_level_q      <= rd_level_d;
            empty_q         <= empty_d;
            almost_empty_q  <= almost_empty_d;
            underflow_q     <= underflow_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign b_rptr        = b_rptr_q;
    assign g_rptr        = g_rptr_q;
    assign r_addr        = b_rptr_q[PTR_WIDTH-1:0];
    assign empty         = empty_q;
    assign almost_empty  = almost_empty_q;
    assign rd_level      = rd_level_q;
    assign underflow     = underflow_q;
    assign underflow_err = underflow_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rptr_handler_lvl.sv
//------------------------------------------------------------------------------
// Module  : tb_rptr_handler_lvl
// Brief   : Table-driven, hand-sequenced and random checks of rptr_handler_lvl
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rptr_handler_lvl;

    localparam int PW  = 3;
    localparam int DEP = 1 << PW;
    localparam int MOD = 2 * DEP;
`ifdef RPTR_INT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 0;
`endif

    logic         rclk = 1'b0;
    logic         rrst_n = 1'b0;
    logic         r_en = 1'b0;
    logic [PW:0]  g_wptr_in = '0;
    logic [PW:0]  ae_thresh = '0;
    logic         clr_err = 1'b0;
    logic [PW:0]  b_rptr, g_rptr, rd_level;
    logic [PW-1:0] r_addr;
    logic         empty, almost_empty, underflow, underflow_err;

    rptr_handler_lvl #(
        .PTR_WIDTH   (PW),
        .SYNC_STAGES (3)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .r_en          (r_en),
        .g_wptr_in     (g_wptr_in),
        .ae_thresh     (ae_thresh),
        .clr_err       (clr_err),
        .b_rptr        (b_rptr),
        .g_rptr        (g_rptr),
        .r_addr        (r_addr),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_level      (rd_level),
        .underflow     (underflow),
        .underflow_err (underflow_err)
    );

    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: counts of entries read / seen written, as plain integers.
    int rp_abs, m_lvl;
    bit m_empty, m_ae, m_uf, m_err;
    int hist[$];

    function automatic int gray_to_int(input logic [PW:0] g);
        for (int b = 0; b < MOD; b++) begin
            if (((b ^ (b >> 1)) % MOD) == int'(g)) return b;
        end
        return 0;
    endfunction

    function automatic logic [PW:0] int_to_gray(input int b);
        int v;
        v = b % MOD;
        return (PW+1)'(v ^ (v >> 1));
    endfunction

    task automatic model_reset();
        rp_abs = 0; m_lvl = 0; m_empty = 1; m_ae = 1; m_uf = 0; m_err = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit ren, input logic [PW:0] gw,
                              input logic [PW:0] thr, input bit clr);
        int w_seen;
        bit pop;
        hist.push_back(gray_to_int(gw));
        while (hist.size() > LAT + 1) void'(hist.pop_front());
        w_seen = (hist.size() > LAT) ? hist[hist.size() - 1 - LAT] : 0;
        pop    = ren && !m_empty;
        m_uf   = ren && m_empty;
        if (pop) rp_abs++;
        m_lvl   = (w_seen - (rp_abs % MOD) + MOD) % MOD;
        m_empty = (m_lvl == 0);
        m_ae    = (m_lvl <= int'(thr));
        if (m_uf)     m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic drive(input bit ren, input logic [PW:0] gw,
                         input logic [PW:0] thr, input bit clr);
        @(negedge rclk);
        r_en = ren; g_wptr_in = gw; ae_thresh = thr; clr_err = clr;
        model_step(ren, gw, thr, clr);
        @(posedge rclk);
        #1;
    endtask

    task automatic cmp(input string name, input int b, input bit e, input bit ae,
                       input int lvl, input bit uf, input bit err);
        int gexp, aexp;
        gexp = (b ^ (b >> 1)) % MOD;
        aexp = b % DEP;
        n_vec++;
        if (b_rptr !== (PW+1)'(b) || g_rptr !== (PW+1)'(gexp) || r_addr !== PW'(aexp) ||
            empty !== e || almost_empty !== ae || rd_level !== (PW+1)'(lvl) ||
            underflow !== uf || underflow_err !== err) begin
            n_bad++;
            $display("FAIL %s: got b=%0d g=%0d a=%0d e=%b ae=%b lvl=%0d uf=%b err=%b; want b=%0d g=%0d a=%0d e=%b ae=%b lvl=%0d uf=%b err=%b",
                     name, b_rptr, g_rptr, r_addr, empty, almost_empty, rd_level, underflow,
                     underflow_err, b, gexp, aexp, e, ae, lvl, uf, err);
        end
    endtask

    task automatic cmp_model(input string name);
        cmp(name, rp_abs % MOD, m_empty, m_ae, m_lvl, m_uf, m_err);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 0; r_en = 0; g_wptr_in = '0; ae_thresh = 4'd2; clr_err = 0;
        model_reset();
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1;
        #1;
    endtask

    typedef struct {
        string       name;
        bit          ren;
        logic [PW:0] gw;
        logic [PW:0] thr;
        bit          clr;
        int          b;
        bit          e;
        bit          ae;
        int          lvl;
        bit          uf;
        bit          err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input bit ren, input logic [PW:0] gw,
                                input bit clr, input int b, input bit e, input bit ae,
                                input int lvl, input bit uf, input bit err);
        vec_t v;
        v.name = nm; v.ren = ren; v.gw = gw; v.thr = 4'd2; v.clr = clr;
        v.b = b; v.e = e; v.ae = ae; v.lvl = lvl; v.uf = uf; v.err = err;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [PW:0] cur_gw;
        int          w_abs, n;

        // Gray codes: bin8=1100, bin12=1010, bin14=1001, bin1=0001.
        add("fill", 0, 4'b1100, 0, 0, 0, 0, 8, 0, 0);
        for (int k = 1; k <= 8; k++)
            add($sformatf("drain%0d", k), 1, 4'b1100, 0, k, k == 8, (8 - k) <= 2, 8 - k, 0, 0);
        add("uf1",      1, 4'b1100, 0, 8, 1, 1, 0, 1, 1);
        add("uf2",      1, 4'b1100, 0, 8, 1, 1, 0, 1, 1);
        add("uf_clr",   1, 4'b1100, 1, 8, 1, 1, 0, 1, 1);
        add("clr",      0, 4'b1100, 1, 8, 1, 1, 0, 0, 0);
        add("lvl4",     0, 4'b1010, 0, 8, 0, 0, 4, 0, 0);
        add("rdwr",     1, 4'b1001, 0, 9, 0, 0, 5, 0, 0);
        for (int k = 1; k <= 5; k++)
            add($sformatf("to14_%0d", k), 1, 4'b1001, 0, 9 + k, k == 5, (5 - k) <= 2, 5 - k, 0, 0);
        add("wrap_fill", 0, 4'b0001, 0, 14, 0, 0, 3, 0, 0);
        add("wrap_rd1",  1, 4'b0001, 0, 15, 0, 1, 2, 0, 0);
        add("wrap_rd2",  1, 4'b0001, 0, 0,  0, 1, 1, 0, 0);
        add("wrap_rd3",  1, 4'b0001, 0, 1,  1, 1, 0, 0, 0);

        do_reset();
        cmp("reset", 0, 1, 1, 0, 0, 0);

        cur_gw = '0;
        foreach (tbl[i]) begin
            if (tbl[i].gw != cur_gw) begin
                repeat (LAT) drive(0, tbl[i].gw, tbl[i].thr, 0);
                cur_gw = tbl[i].gw;
            end
            drive(tbl[i].ren, tbl[i].gw, tbl[i].thr, tbl[i].clr);
            cmp(tbl[i].name, tbl[i].b, tbl[i].e, tbl[i].ae, tbl[i].lvl, tbl[i].uf, tbl[i].err);
        end

        // Asynchronous reset while an underflow pulse is being shown.
        drive(1, 4'b0001, 4'd2, 0);
        cmp_model("pre_rst");
        #3 rrst_n = 0;
        #1 cmp("async_rst", 0, 1, 1, 0, 0, 0);
        r_en = 0; g_wptr_in = '0; clr_err = 0;
        model_reset();
        @(negedge rclk);
        rrst_n = 1;

        // Write-pointer change to flag latency.
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(0, int_to_gray(3), 4'd2, 0);
            if (empty === 1'b0) begin n = k; break; end
        end
        n_vec++;
        if (n != LAT + 1) begin
            n_bad++;
            $display("FAIL sync_latency: got %0d edges, want %0d", n, LAT + 1);
        end
        cmp_model("latency_state");

        // Random traffic against the reference model.
        do_reset();
        cmp_model("rnd_reset");
        w_abs = 0;
        cur_gw = 4'd2;
        for (int c = 0; c < 1500; c++) begin
            int  k;
            bit  ren;
            if (c % 100 == 0) cur_gw = (PW+1)'($urandom_range(0, DEP));
            k = $urandom_range(0, 2);
            if (c % 300 > 200) k = 0;
            if (w_abs + k - rp_abs <= DEP) w_abs += k;
            ren = (c % 300 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(ren, int_to_gray(w_abs), cur_gw, $urandom_range(0, 7) == 0);
            cmp_model($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rptr_handler_lvl.md
Name: rptr_handler_lvl

Overview:
Read-side pointer handler for the async FIFO, successor to the fixed read-pointer block. Keeps the binary and Gray read pointers and the registered empty flag. Adds a read-side fill level, a programmable almost-empty flag, and underflow detection/reporting. Sits in the rclk domain between the synchronised write pointer and the FIFO memory read port.

Parameters:
- PTR_WIDTH, 8, FIFO address width; depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
- SYNC_STAGES, 2, synchroniser flop count (minimum 2); used only when RPTR_INT_SYNC_EN is defined.

Ports:
- rclk  in  1  read clock
- rrst_n  in  1  asynchronous active-low reset
- r_en  in  1  read request
- g_wptr_in  in  PTR_WIDTH+1  Gray write pointer: already synchronised, or raw wclk-domain under RPTR_INT_SYNC_EN
- ae_thresh  in  PTR_WIDTH+1  almost-empty threshold, quasi-static
- clr_err  in  1  clears underflow_err
- b_rptr  out  PTR_WIDTH+1  binary read pointer
- g_rptr  out  PTR_WIDTH+1  Gray read pointer, to the write-side synchroniser
- r_addr  out  PTR_WIDTH  memory read address = b_rptr[PTR_WIDTH-1:0]
- empty  out  1  FIFO empty
- almost_empty  out  1  level <= ae_thresh
- rd_level  out  PTR_WIDTH+1  entries available to read, 0..2**PTR_WIDTH
- underflow  out  1  one-cycle pulse: read attempted while empty
- underflow_err  out  1  sticky underflow flag

Behaviour:
- Reset is rrst_n, asynchronous, active-low; the clock is rclk.
- Reset values: b_rptr=0, g_rptr=0, empty=1, almost_empty=1, rd_level=0, underflow=0, underflow_err=0.
- rd_ok = r_en & ~empty.
- b_rptr_next = b_rptr + rd_ok. Wraps modulo 2**(PTR_WIDTH+1).
- g_rptr_next = (b_rptr_next>>1) ^ b_rptr_next.
- b_rptr and g_rptr register their next values every rclk.
- wbin = gray-to-binary of the synchronised write pointer (combinational XOR-prefix).
- empty <= (g_wptr_sync == g_rptr_next). empty is registered, and the flag is updated in the same cycle as the pop.
- rd_level <= wbin - b_rptr_next, modulo 2**(PTR_WIDTH+1). The maximum legal value is 2**PTR_WIDTH.
- almost_empty <= (level_next <= ae_thresh). ae_thresh=0 makes almost_empty equal to empty.
- Underflow: if r_en & empty, b_rptr holds, and underflow=1 the next cycle. Otherwise underflow=0 the next cycle.
- underflow_err sets on an underflow event and clears on clr_err. If both occur in the same cycle, set wins.
- Latency: flags and level reflect a write 1 rclk after g_wptr_sync changes, plus SYNC_STAGES rclk when the internal synchroniser is present.
- A write-pointer jump of more than one entry between samples is legal. Level and flags follow it directly.
- Full buffer read to empty: level steps N..1, 0. empty asserts in the same cycle level reaches 0.
- Reset mid-operation: everything returns to reset values immediately, with no pending underflow pulse.

Optional Feature:
- Macro: RPTR_INT_SYNC_EN.
- Defined: g_wptr_in is the raw wclk-domain Gray pointer. An internal SYNC_STAGES-deep flop chain on rclk, reset to 0 by rrst_n, produces g_wptr_sync.
- Undefined: g_wptr_sync = g_wptr_in directly. The caller provides synchronisation, and behaviour is otherwise identical.

Decomposition:
- Package fifo_ptr_pkg holds:
  - function gray2bin and function bin2gray, both parametrised by width;
  - localparam MIN_SYNC_STAGES = 2.
- One sub-module: gray_sync (SYNC_STAGES-deep multi-bit flop synchroniser), instantiated only under RPTR_INT_SYNC_EN. It is reusable by the write-side handler.

Test Plan:
- Reset with PTR_WIDTH=3: release rrst_n → empty=1, almost_empty=1, rd_level=0, b_rptr=0, g_rptr=0.
- Fill then drain: g_wptr_in=4'b1100 (bin 8), ae_thresh=2 → rd_level=8, empty=0, almost_empty=0. Then r_en held 8 cycles → level 7..0; almost_empty asserts at level 2; empty asserts with level 0; b_rptr=8, g_rptr=4'b1100.
- Wrap-around: pointers at bin 14/15 with 3 entries written across the wrap → level 3, r_addr 6,7,0, empty after the 3rd read, b_rptr=1.
- Underflow: empty with r_en=1 for 2 cycles → b_rptr unchanged, underflow pulses 2 cycles, underflow_err=1. clr_err together with a new underflow → err stays 1. clr_err alone → 0.
- Simultaneous read and write: level 4, pop while wbin advances by 2 → level 5 next cycle, empty stays 0.
- With RPTR_INT_SYNC_EN, SYNC_STAGES=3: a g_wptr_in change takes effect on empty/rd_level after exactly 4 rclk edges.
